// File: rtl/wb_pkg.sv
// Shared types for the register write-back queue.
// Request record, arbitration flag and default widths.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

endpackage

// File: rtl/wb_fifo_2w1r.sv
// In-order write-back storage: up to two pushes and one pop per cycle.
// Exposes raw entries so the top can run the forwarding search.
module wb_fifo_2w1r
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr0_en,
  input  wb_req_t              wr0_req,
  input  logic                 wr1_en,
  input  wb_req_t              wr1_req,
  input  logic                 rd_en,
  output wb_req_t [DEPTH-1:0]  entries,
  output logic    [PW-1:0]     rd_ptr,
  output logic    [CW-1:0]     count
);

  wb_req_t [DEPTH-1:0] mem;
  logic    [PW-1:0]    wr_ptr;
  logic    [1:0]       n_push;
  logic                do_rd;
  wb_req_t             slot0;

  assign n_push  = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign slot0   = wr0_en ? wr0_req : wr1_req;
  assign do_rd   = rd_en && (count != '0);
  assign entries = mem;

  // Compacted push (older request first), head pop, occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr0_en || wr1_en)
        mem[wr_ptr] <= slot0;
      if (wr0_en && wr1_en)
        mem[wr_ptr + PW'(1)] <= wr1_req;
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(do_rd);
      count  <= count + CW'(n_push) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Two-producer write-back collector feeding the register bank port.
// Arbitration, r0 filtering and youngest-match forwarding live here.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_W-1:0]          a_reg,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_W-1:0]          b_reg,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_reg,
  output logic [DATA_W-1:0]          wb_data,
  input  logic [ADDR_W-1:0]          fwd_reg,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t [DEPTH-1:0] entries;
  wb_req_t             head;
  wb_req_t             a_req;
  wb_req_t             b_req;
  logic    [PW-1:0]    rd_ptr;
  logic    [CW-1:0]    free;
  logic    [PW-1:0]    idx;
  logic                nz;
  logic                push_a;
  logic                push_b;
  logic                contend;
  rr_t                 rr;

  assign nz   = (count != '0);
  assign free = CW'(DEPTH) - count + CW'(nz);

  assign a_req = '{addr: a_reg, data: a_data};
  assign b_req = '{addr: b_reg, data: b_data};

  assign push_a = a_valid && a_ready && (a_reg != '0);
  assign push_b = b_valid && b_ready && (b_reg != '0);

  assign contend = a_valid && b_valid && (free == CW'(1));

  assign head    = entries[rd_ptr];
  assign wb_en   = nz;
  assign wb_reg  = nz ? head.addr : '0;
  assign wb_data = nz ? head.data : '0;

  // Ready: open when two slots free, arbitrate the last slot.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (1'b1)
      (free >= CW'(2)): begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end
      (free == CW'(1)): begin
        a_ready = !b_valid || (a_valid && rr == RR_A);
        b_ready = !a_valid || (b_valid && rr == RR_B);
      end
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
  end

  // Round-robin flag flips after every contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr <= RR_A;
    else if (contend)
      rr <= (rr == RR_A) ? RR_B : RR_A;
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) &&
          (entries[idx].addr == fwd_reg) &&
          (fwd_reg != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  wb_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr0_en  (push_a),
    .wr0_req (a_req),
    .wr1_en  (push_b),
    .wr1_req (b_req),
    .rd_en   (nz),
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic [4:0]  a_reg = '0;
  logic [4:0]  b_reg = '0;
  logic [4:0]  fwd_reg = '0;
  logic [31:0] a_data = '0;
  logic [31:0] b_data = '0;
  logic        a_ready;
  logic        b_ready;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   mrr;
  bit   m_ea;
  bit   m_eb;
  int   m_free;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic [4:0]  fr;
    int          cnt;
    logic        en;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] fd;
    logic        ardy;
    logic        brdy;
  } vec_t;

  vec_t tbl[7];
  bit   grants[$];
  int   max_cnt;

  reg_writeback_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .fwd_reg  (fwd_reg),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic bv,
                        input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] fr);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    fwd_reg = fr;
  endtask

  // Expected outputs from the list of pending writes.
  task automatic check_model();
    int n;
    logic        eh;
    logic [31:0] efd;
    n = q.size();
    m_free = DEPTH - n + ((n != 0) ? 1 : 0);
    if (m_free >= 2) begin
      m_ea = 1; m_eb = 1;
    end else if (m_free == 1) begin
      if (a_valid && b_valid) begin
        m_ea = !mrr; m_eb = mrr;
      end else begin
        m_ea = !b_valid; m_eb = !a_valid;
      end
    end else begin
      m_ea = 0; m_eb = 0;
    end
    eh = 0; efd = 0;
    if (fwd_reg != 0)
      foreach (q[k])
        if (q[k].r == fwd_reg) begin
          eh = 1; efd = q[k].d;
        end
    chk("count", 32'(count), 32'(n));
    chk("wb_en", 32'(wb_en), 32'(n != 0));
    chk("wb_reg", 32'(wb_reg), (n != 0) ? 32'(q[0].r) : 32'd0);
    chk("wb_data", wb_data, (n != 0) ? q[0].d : 32'd0);
    chk("fwd_hit", 32'(fwd_hit), 32'(eh));
    chk("fwd_data", fwd_data, efd);
    chk("a_ready", 32'(a_ready), 32'(m_ea));
    chk("b_ready", 32'(b_ready), 32'(m_eb));
  endtask

  // Clock edge: retire head, accept granted requests, update arbiter.
  task automatic advance();
    bit ta, tb, ct;
    ta = a_valid && m_ea;
    tb = b_valid && m_eb;
    ct = a_valid && b_valid && (m_free == 1);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (ta && a_reg != 0) q.push_back('{a_reg, a_data});
    if (tb && b_reg != 0) q.push_back('{b_reg, b_data});
    if (ct) mrr = !mrr;
    @(negedge clk);
  endtask

  task automatic apply(input logic av, input logic [4:0] ar,
                       input logic [31:0] ad, input logic bv,
                       input logic [4:0] br, input logic [31:0] bd,
                       input logic [4:0] fr);
    set_in(av, ar, ad, bv, br, bd, fr);
    #1;
    check_model();
    advance();
  endtask

  initial begin
    tbl[0] = '{1, 15, 1515, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 15, 1, 1, 15, 1515, 1, 1515, 1, 1};
    tbl[2] = '{1, 10, 111, 1, 10, 222, 10, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 10, 2, 1, 10, 111, 1, 222, 1, 1};
    tbl[4] = '{1, 0, 999, 0, 0, 0, 10, 1, 1, 10, 222, 1, 222, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 1};

    mrr = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_ready", 32'({a_ready, b_ready}), 3);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].av, tbl[i].ar, tbl[i].ad,
             tbl[i].bv, tbl[i].br, tbl[i].bd, tbl[i].fr);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_wb_reg", i), 32'(wb_reg), 32'(tbl[i].wr));
      chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].wd);
      chk($sformatf("v%0d_fwd_hit", i), 32'(fwd_hit), 32'(tbl[i].hit));
      chk($sformatf("v%0d_fwd_data", i), fwd_data, tbl[i].fd);
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ardy));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].brdy));
      check_model();
      advance();
    end

    max_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      set_in(1, 5'(1 + k % 7), 1000 + k, 1, 5'(9 + k % 5), 2000 + k,
             5'(1 + k % 14));
      #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (q.size() == DEPTH) grants.push_back(a_ready);
      check_model();
      advance();
    end
    chk("fill_max_count", 32'(max_cnt), DEPTH);
    chk("contended_seen", 32'(grants.size() >= 4), 1);
    for (int k = 1; k < grants.size(); k++)
      chk($sformatf("rr_alt%0d", k), 32'(grants[k]),
          32'(!grants[k-1]));
    for (int k = 0; k < 6; k++) apply(0, 0, 0, 0, 0, 0, 0);

    apply(1, 1, 11, 1, 2, 22, 0);
    apply(1, 3, 33, 1, 4, 44, 0);
    set_in(0, 0, 0, 0, 0, 0, 4);
    #1;
    check_model();
    chk("pre_rst_count", 32'(count), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_wb_en", 32'(wb_en), 0);
    chk("mid_rst_fwd", 32'(fwd_hit), 0);
    q.delete();
    mrr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 5, 6969, 0, 0, 0, 5);
    set_in(0, 0, 0, 0, 0, 0, 5);
    #1;
    chk("post_rst_reg", 32'(wb_reg), 5);
    chk("post_rst_data", wb_data, 6969);
    chk("post_rst_fwd", fwd_data, 6969);
    check_model();
    advance();

    for (int k = 0; k < 600; k++)
      apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
